// File: rtl/spacing_fn_unit.sv
// spacing_fn_unit: four-lane pipelined reciprocal s = floor(2^24 / t), saturated to 4095.
// Define SPACING_FN_ROUND_EN for round-to-nearest (13-bit quotient of 2^25 / t, latency 13).
module spacing_fn_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [20:0] i_data_1,
  input  logic [20:0] i_data_2,
  input  logic [20:0] i_data_3,
  input  logic [20:0] i_data_4,
  output logic        o_valid,
  output logic [12:0] o_data_1,
  output logic [12:0] o_data_2,
  output logic [12:0] o_data_3,
  output logic [12:0] o_data_4
);

`ifdef SPACING_FN_ROUND_EN
  localparam int QW = 13;
`else
  localparam int QW = 12;
`endif
  // One quotient bit per stage, so the stage count equals the quotient width.
  localparam int NS = QW;
  localparam int RW = QW + 13;
  localparam logic [RW-1:0] DIVIDEND = {1'b1, {(RW-1){1'b0}}};
  localparam logic [20:0]   SAT_T    = 21'd4096;

  // One restoring step: trial-subtract t << bitpos from the partial remainder.
  // Returns {quotient_bit, next_remainder}.
  function automatic logic [RW:0] div_step(input logic [RW-1:0] rem,
                                           input logic [20:0]   t,
                                           input int            bitpos);
    logic [RW+20:0] div_sh;
    logic [RW+20:0] rem_w;
    logic [RW-1:0]  rem_n;
    logic           qb;
    div_sh = {{RW{1'b0}}, t} << bitpos;
    rem_w  = {21'd0, rem};
    qb     = (rem_w >= div_sh);
    rem_n  = qb ? (rem - div_sh[RW-1:0]) : rem;
    return {qb, rem_n};
  endfunction

  logic [20:0] in_t [4];
  assign in_t[0] = i_data_1;
  assign in_t[1] = i_data_2;
  assign in_t[2] = i_data_3;
  assign in_t[3] = i_data_4;

  // Pipeline state: stage s holds the quotient with bits QW-1..QW-1-s resolved.
  logic [NS-1:0] vld_r;
  logic [20:0]   t_r   [NS-1][4];
  logic [RW-1:0] rem_r [NS-1][4];
  logic [QW-1:0] q_r   [NS][4];
  logic [3:0]    sat_r [NS];

  // Operands feeding each stage: stage 0 takes the ports, stage s takes stage s-1.
  logic [20:0]   prv_t   [NS][4];
  logic [RW-1:0] prv_rem [NS][4];
  logic [QW-1:0] prv_q   [NS][4];
  logic [3:0]    prv_sat [NS];

  logic [RW-1:0] nxt_rem [NS-1][4];
  logic [QW-1:0] nxt_q   [NS][4];

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      prv_t[0][l]   = in_t[l];
      prv_rem[0][l] = DIVIDEND;
      prv_q[0][l]   = '0;
      prv_sat[0][l] = (in_t[l] <= SAT_T);
    end
    for (int s = 1; s < NS; s++) begin
      prv_sat[s] = sat_r[s-1];
      for (int l = 0; l < 4; l++) begin
        prv_t[s][l]   = t_r[s-1][l];
        prv_rem[s][l] = rem_r[s-1][l];
        prv_q[s][l]   = q_r[s-1][l];
      end
    end
  end

  always_comb begin
    logic [RW:0] step;
    step = '0;
    for (int s = 0; s < NS - 1; s++) begin
      for (int l = 0; l < 4; l++) begin
        step          = div_step(prv_rem[s][l], prv_t[s][l], QW - 1 - s);
        nxt_q[s][l]   = prv_q[s][l] | ({{(QW-1){1'b0}}, step[RW]} << (QW - 1 - s));
        nxt_rem[s][l] = step[RW-1:0];
      end
    end
    // The last stage resolves bit 0; its remainder is not needed.
    for (int l = 0; l < 4; l++) begin
      step           = div_step(prv_rem[NS-1][l], prv_t[NS-1][l], 0);
      nxt_q[NS-1][l] = prv_q[NS-1][l] | {{(QW-1){1'b0}}, step[RW]};
    end
  end

  // Only the valid bits are reset; data registers shift unconditionally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
    end else begin
      vld_r <= {vld_r[NS-2:0], i_valid};
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      sat_r[s] <= prv_sat[s];
      for (int l = 0; l < 4; l++) begin
        q_r[s][l] <= nxt_q[s][l];
      end
    end
    for (int s = 0; s < NS - 1; s++) begin
      for (int l = 0; l < 4; l++) begin
        t_r[s][l]   <= prv_t[s][l];
        rem_r[s][l] <= nxt_rem[s][l];
      end
    end
  end

  logic [11:0] res [4];

  always_comb begin
    for (int l = 0; l < 4; l++) begin
`ifdef SPACING_FN_ROUND_EN
      res[l] = sat_r[NS-1][l] ? 12'hFFF
                              : 12'(({1'b0, q_r[NS-1][l]} + 14'd1) >> 1);
`else
      res[l] = sat_r[NS-1][l] ? 12'hFFF : q_r[NS-1][l];
`endif
    end
  end

  // Output data holds its last value between valid results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid  <= 1'b0;
      o_data_1 <= '0;
      o_data_2 <= '0;
      o_data_3 <= '0;
      o_data_4 <= '0;
    end else begin
      o_valid <= vld_r[NS-1];
      if (vld_r[NS-1]) begin
        o_data_1 <= {1'b0, res[0]};
        o_data_2 <= {1'b0, res[1]};
        o_data_3 <= {1'b0, res[2]};
        o_data_4 <= {1'b0, res[3]};
      end
    end
  end

endmodule

// File: tb/tb_spacing_fn_unit.sv
// Self-checking bench for spacing_fn_unit: table vectors, random streaming against a
// reference model, gap and mid-stream reset sequences. Honours SPACING_FN_ROUND_EN.
`timescale 1ns/1ps
module tb_spacing_fn_unit;

`ifdef SPACING_FN_ROUND_EN
  localparam int L = 13;
`else
  localparam int L = 12;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [20:0] i_data_1, i_data_2, i_data_3, i_data_4;
  logic        o_valid;
  logic [12:0] o_data_1, o_data_2, o_data_3, o_data_4;

  spacing_fn_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .i_data_1 (i_data_1),
    .i_data_2 (i_data_2),
    .i_data_3 (i_data_3),
    .i_data_4 (i_data_4),
    .o_valid  (o_valid),
    .o_data_1 (o_data_1),
    .o_data_2 (o_data_2),
    .o_data_3 (o_data_3),
    .o_data_4 (o_data_4)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required end before 500000ns");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [12:0] ref_s(input logic [20:0] t);
    longint unsigned q;
    if (t <= 21'd4096) return 13'd4095;
`ifdef SPACING_FN_ROUND_EN
    q = ((64'd33554432 / 64'(t)) + 64'd1) / 64'd2;
`else
    q = 64'd16777216 / 64'(t);
`endif
    if (q > 64'd4095) q = 64'd4095;
    return 13'(q);
  endfunction

  function automatic logic [20:0] rnd_t();
    case ($urandom_range(0, 7))
      0:       return 21'($urandom_range(0, 4200));
      1:       return 21'(2097151 - $urandom_range(0, 1000));
      default: return 21'($urandom_range(0, 2097151));
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [51:0] exp_q[$];
  int unsigned exp_cyc_q[$];

  // Driver: one call = one cycle of input, applied just after the falling edge.
  task automatic drive(input logic v, input logic [20:0] t0, input logic [20:0] t1,
                       input logic [20:0] t2, input logic [20:0] t3);
    @(negedge clk);
    #1;
    i_valid  = v;
    i_data_1 = t0;
    i_data_2 = t1;
    i_data_3 = t2;
    i_data_4 = t3;
    if (v) begin
      exp_q.push_back({ref_s(t0), ref_s(t1), ref_s(t2), ref_s(t3)});
      exp_cyc_q.push_back(cyc + 1 + L);
    end
  endtask

  task automatic drive_idle();
    drive(1'b0, rnd_t(), rnd_t(), rnd_t(), rnd_t());
  endtask

  task automatic drive_rand();
    drive(1'b1, rnd_t(), rnd_t(), rnd_t(), rnd_t());
  endtask

  // Every falling edge: o_valid must match the expected arrival schedule.
  always @(negedge clk) begin
    logic exp_v;
    exp_v = (exp_cyc_q.size() != 0) && (exp_cyc_q[0] == cyc);
    check("o_valid", 64'(o_valid), 64'(exp_v));
    if (exp_v) begin
      check("o_data", 64'({o_data_1, o_data_2, o_data_3, o_data_4}), 64'(exp_q[0]));
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
  end

  task automatic wait_out(input int unsigned sent, input string name);
    int waited;
    waited = 0;
    while (o_valid !== 1'b1 && waited < 4 * L) begin
      @(negedge clk);
      waited++;
    end
    if (o_valid !== 1'b1) check({name, "_timeout"}, 64'd0, 64'd1);
    else                  check({name, "_latency"}, 64'(cyc - sent), 64'(L));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [20:0] t  [4];
    logic [12:0] et [4];
    logic [12:0] er [4];
  } vec_t;

  localparam int NV = 4;
  vec_t vecs [NV];

  task automatic set_vec(input int i, input string name,
                         input int t1, input int t2, input int t3, input int t4,
                         input int e1, input int e2, input int e3, input int e4,
                         input int r1, input int r2, input int r3, input int r4);
    vecs[i].name = name;
    vecs[i].t[0] = 21'(t1);  vecs[i].t[1] = 21'(t2);  vecs[i].t[2] = 21'(t3);  vecs[i].t[3] = 21'(t4);
    vecs[i].et[0] = 13'(e1); vecs[i].et[1] = 13'(e2); vecs[i].et[2] = 13'(e3); vecs[i].et[3] = 13'(e4);
    vecs[i].er[0] = 13'(r1); vecs[i].er[1] = 13'(r2); vecs[i].er[2] = 13'(r3); vecs[i].er[3] = 13'(r4);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int unsigned sent;
    logic [12:0] got [4];
    logic [12:0] want;

    set_vec(0, "pow2",     8192, 16384, 2097151, 4097,  2048, 1024, 8, 4095,  2048, 1024, 8, 4095);
    set_vec(1, "sat",      0, 1, 4096, 4097,            4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095);
    set_vec(2, "rounding", 10000, 12288, 951424, 65535, 1677, 1365, 17, 256,  1678, 1365, 18, 256);
    set_vec(3, "edges",    4098, 8191, 100000, 1048576, 4094, 2048, 167, 16,  4094, 2048, 168, 16);

    rst_n = 1'b1;
    i_valid = 1'b0;
    i_data_1 = '0; i_data_2 = '0; i_data_3 = '0; i_data_4 = '0;

    // Reset then idle
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("reset_o_valid", 64'(o_valid), 64'd0);
    check("reset_o_data", 64'({o_data_1, o_data_2, o_data_3, o_data_4}), 64'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_idle();
      check("idle_o_data", 64'({o_data_1, o_data_2, o_data_3, o_data_4}), 64'd0);
    end

    // Table vectors: one isolated sample each, latency and lanes checked by hand
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vecs[i].t[0], vecs[i].t[1], vecs[i].t[2], vecs[i].t[3]);
      sent = cyc + 1;
      drive_idle();
      wait_out(sent, vecs[i].name);
      got[0] = o_data_1; got[1] = o_data_2; got[2] = o_data_3; got[3] = o_data_4;
      for (int l = 0; l < 4; l++) begin
`ifdef SPACING_FN_ROUND_EN
        want = vecs[i].er[l];
`else
        want = vecs[i].et[l];
`endif
        check($sformatf("%s_lane%0d", vecs[i].name, l + 1), 64'(got[l]), 64'(want));
      end
      repeat (3) drive_idle();
    end

    // Streaming: 250 back-to-back random sets
    for (int i = 0; i < 250; i++) drive_rand();
    repeat (L + 4) drive_idle();

    // Input gap of 3 cycles must reappear as a 3-cycle output gap
    repeat (10) drive_rand();
    repeat (3) drive_idle();
    repeat (10) drive_rand();
    repeat (L + 4) drive_idle();

    // Reset mid-stream with 5 samples in flight behind a gap
    repeat (10) drive_rand();
    repeat (3) drive_idle();
    repeat (5) drive_rand();
    @(posedge clk);
    #2;
    i_valid = 1'b0;
    check("pre_reset_o_valid", 64'(o_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_o_valid_drop", 64'(o_valid), 64'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2 * L) drive_idle();

    // First sample after reset
    drive(1'b1, 21'd8192, 21'd0, 21'd65535, 21'd2097151);
    sent = cyc + 1;
    drive_idle();
    wait_out(sent, "post_reset");
    repeat (L + 4) drive_idle();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
